// File: rtl/adc_pkg.sv
// Shared constants and FSM state encoding for the ADC frame filter.
package adc_pkg;
  localparam int ADC_W = 12;
  localparam logic [1:0] FRAME_CH7 = 2'd0;
  localparam logic [1:0] FRAME_CH5 = 2'd1;
  localparam logic [1:0] FRAME_CH6 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_UPDATE,
    ST_OUTPUT
  } state_t;
endpackage

// File: rtl/adc_frame_filter_if.sv
// Bundle between the ADC controller outputs, the frame filter and navigation logic.
interface adc_frame_filter_if;
  import adc_pkg::*;

  logic [1:0]       data_frame;
  logic [ADC_W-1:0] d_in_ch5;
  logic [ADC_W-1:0] d_in_ch6;
  logic [ADC_W-1:0] d_in_ch7;
  logic [ADC_W-1:0] f_ch5;
  logic [ADC_W-1:0] f_ch6;
  logic [ADC_W-1:0] f_ch7;
  logic [2:0]       line_det;
  logic             out_valid;
  logic             win_full;
  logic             err_overrun;
  state_t           fsm_state;

  // out_valid is a one-cycle strobe with no back-pressure: f_ch*, line_det and
  // win_full are valid in the strobe cycle and hold until the next strobe.
  modport master (
    output data_frame, d_in_ch5, d_in_ch6, d_in_ch7,
    input  f_ch5, f_ch6, f_ch7, line_det, out_valid, win_full, err_overrun, fsm_state
  );
  modport slave (
    input  data_frame, d_in_ch5, d_in_ch6, d_in_ch7,
    output f_ch5, f_ch6, f_ch7, line_det, out_valid, win_full, err_overrun, fsm_state
  );
endinterface

// File: rtl/adc_frame_filter_mavg_ch.sv
// One channel: moving-average window, running sum and hysteresis detect bit.
module mavg_ch
  import adc_pkg::*;
#(
  parameter int               AVG_LOG2 = 2,
  parameter logic [ADC_W-1:0] TH_HI    = 12'd1600,
  parameter logic [ADC_W-1:0] TH_LO    = 12'd1400
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             upd,
  input  logic             out_en,
  input  logic [ADC_W-1:0] sample,
  output logic [ADC_W-1:0] avg,
  output logic             det
);
  localparam int TAPS = 1 << AVG_LOG2;
  localparam int SW   = ADC_W + AVG_LOG2;

  logic [ADC_W-1:0] win [TAPS];
  logic [SW-1:0]    sum;
  logic [ADC_W-1:0] avg_q;
  logic [ADC_W-1:0] avg_new;
  logic             det_q;
  logic             det_new;

  // The sum always equals the window contents, so sum - oldest + sample fits in SW bits.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) win[i] <= '0;
      sum   <= '0;
      avg_q <= '0;
      det_q <= 1'b0;
    end else begin
      if (upd) begin
        sum    <= sum - SW'(win[TAPS-1]) + SW'(sample);
        win[0] <= sample;
        for (int i = 1; i < TAPS; i++) win[i] <= win[i-1];
      end
      if (out_en) begin
        avg_q <= avg_new;
        det_q <= det_new;
      end
    end
  end

  assign avg_new = ADC_W'(sum >> AVG_LOG2);

  always_comb begin
    det_new = det_q;
    if (avg_new >= TH_HI)     det_new = 1'b1;
    else if (avg_new < TH_LO) det_new = 1'b0;
  end

  // New values are visible during the output strobe itself, then held in avg_q/det_q.
  assign avg = out_en ? avg_new : avg_q;
  assign det = out_en ? det_new : det_q;
endmodule

// File: rtl/adc_frame_filter.sv
// Detects completed ADC scans, captures ch5/6/7 after settling and filters them.
module adc_frame_filter
  import adc_pkg::*;
#(
  parameter int               AVG_LOG2 = 2,
  parameter int               SETTLE   = 4,
  parameter logic [ADC_W-1:0] TH_HI    = 12'd1600,
  parameter logic [ADC_W-1:0] TH_LO    = 12'd1400
) (
  input  logic               clk_50,
  input  logic               rst_n,
  adc_frame_filter_if.slave  bus
);
  localparam int TAPS = 1 << AVG_LOG2;
  localparam int FW   = AVG_LOG2 + 1;
  localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [1:0]       frame_m, frame_s, frame_p;
  logic             wrap_evt;
  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [ADC_W-1:0] cap5, cap6, cap7;
  logic [FW-1:0]    fill;
  logic             win_full_q;
  logic             err_q;
  logic             upd, out_en, fill_sat;

  // A scan ends when the controller wraps from the ch6 slot back to the ch7 slot.
  assign wrap_evt = (frame_p == FRAME_CH6) && (frame_s == FRAME_CH7);
  assign upd      = (state == ST_UPDATE);
  assign out_en   = (state == ST_OUTPUT);
  assign fill_sat = (fill == FW'(TAPS));

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      frame_m    <= '0;
      frame_s    <= '0;
      frame_p    <= '0;
      state      <= ST_IDLE;
      cnt        <= '0;
      cap5       <= '0;
      cap6       <= '0;
      cap7       <= '0;
      fill       <= '0;
      win_full_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      frame_m <= bus.data_frame;
      frame_s <= frame_m;
      frame_p <= frame_s;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      if (state == ST_CAPTURE) begin
        cap5 <= bus.d_in_ch5;
        cap6 <= bus.d_in_ch6;
        cap7 <= bus.d_in_ch7;
      end
      if (upd && !fill_sat) fill <= fill + FW'(1);
      if (out_en && fill_sat) win_full_q <= 1'b1;
      if (wrap_evt && state != ST_IDLE) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (wrap_evt) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CW'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) state_nxt = ST_CAPTURE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      ST_CAPTURE: state_nxt = ST_UPDATE;
      ST_UPDATE:  state_nxt = ST_OUTPUT;
      ST_OUTPUT:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  mavg_ch #(.AVG_LOG2(AVG_LOG2), .TH_HI(TH_HI), .TH_LO(TH_LO)) u_ch5 (
    .clk_50(clk_50), .rst_n(rst_n), .upd(upd), .out_en(out_en),
    .sample(cap5), .avg(bus.f_ch5), .det(bus.line_det[0])
  );
  mavg_ch #(.AVG_LOG2(AVG_LOG2), .TH_HI(TH_HI), .TH_LO(TH_LO)) u_ch6 (
    .clk_50(clk_50), .rst_n(rst_n), .upd(upd), .out_en(out_en),
    .sample(cap6), .avg(bus.f_ch6), .det(bus.line_det[1])
  );
  mavg_ch #(.AVG_LOG2(AVG_LOG2), .TH_HI(TH_HI), .TH_LO(TH_LO)) u_ch7 (
    .clk_50(clk_50), .rst_n(rst_n), .upd(upd), .out_en(out_en),
    .sample(cap7), .avg(bus.f_ch7), .det(bus.line_det[2])
  );

  assign bus.out_valid   = out_en;
  assign bus.win_full    = win_full_q | (out_en && fill_sat);
  assign bus.err_overrun = err_q;
  assign bus.fsm_state   = state;
endmodule

// File: tb/tb_adc_frame_filter.sv
// Directed bench for adc_frame_filter: reset, latency/fill, hysteresis, full scale, overrun.
module tb_adc_frame_filter;
  import adc_pkg::*;

  localparam int SETTLE = 4;
  localparam int LAT    = SETTLE + 6;  // negedges from the 2->0 drive to the strobe
  localparam int HOLD   = 20;

  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int         p_cnt, p_lat;
  logic [11:0] p_f5, p_f6, p_f7;
  logic [2:0]  p_ld;
  logic        p_wf;

  adc_frame_filter_if bus();

  adc_frame_filter #(.AVG_LOG2(2), .SETTLE(SETTLE), .TH_HI(12'd1600), .TH_LO(12'd1400)) dut (
    .clk_50(clk_50),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk_50 = ~clk_50;

  task automatic drive_frame(input logic [1:0] v, input int hold);
    @(posedge clk_50);
    #1 bus.data_frame = v;
    repeat (hold) @(posedge clk_50);
  endtask

  // Observe n negedges, count strobes and latch outputs at the first one.
  task automatic watch(input int n);
    p_cnt = 0; p_lat = -1;
    p_f5 = '0; p_f6 = '0; p_f7 = '0; p_ld = '0; p_wf = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_50);
      if (bus.out_valid === 1'b1) begin
        p_cnt++;
        if (p_lat < 0) begin
          p_lat = k;
          p_f5 = bus.f_ch5; p_f6 = bus.f_ch6; p_f7 = bus.f_ch7;
          p_ld = bus.line_det; p_wf = bus.win_full;
        end
      end
    end
  endtask

  task automatic run_scan(input logic [11:0] d5, input logic [11:0] d6, input logic [11:0] d7);
    bus.d_in_ch5 = d5; bus.d_in_ch6 = d6; bus.d_in_ch7 = d7;
    drive_frame(2'd1, HOLD);
    drive_frame(2'd2, HOLD);
    @(posedge clk_50);
    #1 bus.data_frame = 2'd0;
    watch(40);
  endtask

  task automatic test_reset;
    bus.data_frame = 2'd0; bus.d_in_ch5 = '0; bus.d_in_ch6 = '0; bus.d_in_ch7 = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk_50);
    checks++; if ({bus.f_ch5, bus.f_ch6, bus.f_ch7} !== 36'd0) begin errors++; $display("FAIL reset_f got %h exp 0", {bus.f_ch5, bus.f_ch6, bus.f_ch7}); end
    checks++; if ({bus.line_det, bus.out_valid, bus.win_full, bus.err_overrun} !== 6'd0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {bus.line_det, bus.out_valid, bus.win_full, bus.err_overrun}); end
    rst_n = 1'b1;
    watch(1000);
    checks++; if (p_cnt !== 0) begin errors++; $display("FAIL idle_no_valid got %0d exp 0", p_cnt); end
    checks++; if ({bus.f_ch5, bus.f_ch6, bus.f_ch7, bus.line_det, bus.win_full, bus.err_overrun} !== 41'd0) begin errors++; $display("FAIL idle_outputs got %h exp 0", {bus.f_ch5, bus.f_ch6, bus.f_ch7, bus.line_det, bus.win_full, bus.err_overrun}); end
  endtask

  task automatic test_latency_fill;
    for (int i = 0; i < 4; i++) begin
      run_scan(12'd2000, 12'd0, 12'd0);
      checks++; if (p_cnt !== 1) begin errors++; $display("FAIL fill_pulses scan%0d got %0d exp 1", i, p_cnt); end
      checks++; if (p_lat !== LAT) begin errors++; $display("FAIL fill_latency scan%0d got %0d exp %0d", i, p_lat, LAT); end
      checks++; if (p_f5 !== 12'(500 * (i + 1))) begin errors++; $display("FAIL fill_f5 scan%0d got %0d exp %0d", i, p_f5, 500 * (i + 1)); end
      checks++; if (p_wf !== (i == 3)) begin errors++; $display("FAIL fill_win_full scan%0d got %b exp %b", i, p_wf, (i == 3)); end
      checks++; if (p_ld !== ((i == 3) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL fill_line_det scan%0d got %b", i, p_ld); end
    end
    checks++; if (bus.f_ch5 !== 12'd2000 || bus.win_full !== 1'b1) begin errors++; $display("FAIL fill_hold got f5=%0d wf=%b exp 2000 1", bus.f_ch5, bus.win_full); end
  endtask

  task automatic test_hysteresis;
    for (int i = 0; i < 4; i++) begin
      run_scan(12'd2000, 12'd1600, 12'd0);
      checks++; if (p_f6 !== 12'(400 * (i + 1)) || p_ld[1] !== (i == 3)) begin errors++; $display("FAIL hyst_rise scan%0d got f6=%0d det=%b exp %0d %b", i, p_f6, p_ld[1], 400 * (i + 1), (i == 3)); end
    end
    for (int i = 0; i < 4; i++) begin
      run_scan(12'd2000, 12'd1400, 12'd0);
      checks++; if (p_f6 !== 12'(1600 - 50 * (i + 1)) || p_ld[1] !== 1'b1) begin errors++; $display("FAIL hyst_hold scan%0d got f6=%0d det=%b exp %0d 1", i, p_f6, p_ld[1], 1600 - 50 * (i + 1)); end
    end
    for (int i = 0; i < 4; i++) begin
      run_scan(12'd2000, 12'd1399, 12'd0);
      checks++; if (p_f6 !== 12'd1399 || p_ld !== 3'b001) begin errors++; $display("FAIL hyst_clear scan%0d got f6=%0d ld=%b exp 1399 001", i, p_f6, p_ld); end
    end
  endtask

  task automatic test_full_scale;
    for (int i = 0; i < 4; i++) begin
      run_scan(12'hFFF, 12'hFFF, 12'hFFF);
      checks++; if (p_cnt !== 1) begin errors++; $display("FAIL full_pulses scan%0d got %0d exp 1", i, p_cnt); end
    end
    checks++; if ({p_f5, p_f6, p_f7} !== {3{12'd4095}}) begin errors++; $display("FAIL full_values got %0d %0d %0d exp 4095", p_f5, p_f6, p_f7); end
    checks++; if (p_ld !== 3'b111) begin errors++; $display("FAIL full_line_det got %b exp 111", p_ld); end
  endtask

  task automatic test_ignored;
    drive_frame(2'd1, HOLD);
    @(posedge clk_50); #1 bus.data_frame = 2'd0;
    watch(40);
    checks++; if (p_cnt !== 0) begin errors++; $display("FAIL ign_0_1_0 got %0d exp 0", p_cnt); end
    @(posedge clk_50); #1 bus.data_frame = 2'd2;
    watch(HOLD);
    checks++; if (p_cnt !== 0) begin errors++; $display("FAIL ign_0_2 got %0d exp 0", p_cnt); end
    @(posedge clk_50); #1 bus.data_frame = 2'd0;
    watch(40);
    checks++; if (p_cnt !== 1 || p_f5 !== 12'd4095) begin errors++; $display("FAIL ign_2_0 got pulses=%0d f5=%0d exp 1 4095", p_cnt, p_f5); end
  endtask

  task automatic test_overrun;
    checks++; if (bus.err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_before got %b exp 0", bus.err_overrun); end
    drive_frame(2'd1, HOLD);
    drive_frame(2'd2, HOLD);
    @(posedge clk_50); #1 bus.data_frame = 2'd0;
    @(posedge clk_50); #1 bus.data_frame = 2'd2;
    @(posedge clk_50); #1 bus.data_frame = 2'd0;
    watch(40);
    checks++; if (p_cnt !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", p_cnt); end
    checks++; if (bus.err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", bus.err_overrun); end
    watch(100);
    checks++; if (bus.err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", bus.err_overrun); end
  endtask

  task automatic test_reset_midop;
    bus.d_in_ch5 = 12'd1000; bus.d_in_ch6 = 12'd1000; bus.d_in_ch7 = 12'd1000;
    drive_frame(2'd1, HOLD);
    drive_frame(2'd2, HOLD);
    @(posedge clk_50); #1 bus.data_frame = 2'd0;
    watch(LAT - 2);
    checks++; if (p_cnt !== 0) begin errors++; $display("FAIL mid_early_valid got %0d exp 0", p_cnt); end
    @(negedge clk_50);
    checks++; if (bus.fsm_state !== ST_UPDATE) begin errors++; $display("FAIL mid_state got %0d exp %0d", bus.fsm_state, ST_UPDATE); end
    rst_n = 1'b0;
    watch(10);
    checks++; if (p_cnt !== 0) begin errors++; $display("FAIL mid_no_valid got %0d exp 0", p_cnt); end
    checks++; if ({bus.f_ch5, bus.f_ch6, bus.f_ch7, bus.line_det, bus.win_full, bus.err_overrun} !== 41'd0) begin errors++; $display("FAIL mid_outputs got %h exp 0", {bus.f_ch5, bus.f_ch6, bus.f_ch7, bus.line_det, bus.win_full, bus.err_overrun}); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50);
    run_scan(12'hFFF, 12'hFFF, 12'hFFF);
    checks++; if (p_cnt !== 1 || p_lat !== LAT) begin errors++; $display("FAIL post_rst_pulse got %0d lat %0d exp 1 %0d", p_cnt, p_lat, LAT); end
    checks++; if ({p_f5, p_f6, p_f7} !== {3{12'd1023}} || p_ld !== 3'b000 || p_wf !== 1'b0) begin errors++; $display("FAIL post_rst_vals got %0d %0d %0d ld=%b wf=%b exp 1023 000 0", p_f5, p_f6, p_f7, p_ld, p_wf); end
  endtask

  initial begin
    test_reset;
    test_latency_fill;
    test_hysteresis;
    test_full_scale;
    test_ignored;
    test_overrun;
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_frame_filter.md
Name: adc_frame_filter

Overview:
- Downstream consumer of the ADC128S022 controller's parallel outputs (ch5/ch6/ch7, 12-bit) and its 2-bit data_frame index.
- Detects each completed three-channel scan, re-times the quasi-static values into the clk_50 domain, and runs a per-channel moving average.
- Applies hysteresis thresholds and presents filtered values plus a 3-bit line-detect vector with a one-cycle valid strobe to the navigation logic.

Parameters:
- AVG_LOG2, 2, log2 of averaging window (window = 4 samples); legal 1..4
- SETTLE, 4, clk_50 cycles waited after scan-complete event before capturing channel buses
- TH_HI, 12'd1600, filtered value at or above which a channel's detect bit sets
- TH_LO, 12'd1400, filtered value below which a channel's detect bit clears; must be < TH_HI

Ports:
- clk_50  input  1  50 MHz system clock
- rst_n  input  1  asynchronous active-low reset
- data_frame  input  2  frame index from ADC controller: 0=ch7, 1=ch5, 2=ch6; asynchronous to clk_50
- d_in_ch5  input  12  raw ch5 sample
- d_in_ch6  input  12  raw ch6 sample
- d_in_ch7  input  12  raw ch7 sample
- f_ch5  output  12  filtered ch5
- f_ch6  output  12  filtered ch6
- f_ch7  output  12  filtered ch7
- line_det  output  3  hysteresis detect bits, {ch7, ch6, ch5}
- out_valid  output  1  one-cycle pulse: f_ch* and line_det updated this cycle
- win_full  output  1  high once every averaging window holds 2^AVG_LOG2 real samples
- err_overrun  output  1  sticky: a scan-complete event arrived while FSM was busy

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: all f_ch* = 0, line_det = 0, out_valid = 0, win_full = 0, err_overrun = 0; window registers, running sums, fill counter = 0; FSM = IDLE. Reset mid-operation aborts any in-progress update, and no out_valid is emitted.
- data_frame passes through a 2-flop synchronizer (frame_s), then a registered copy (frame_p).
- wrap_evt = (frame_p == 2) && (frame_s == 0). Any other transition, including 0->2, 1->0, and no change, is ignored.
- FSM states:
  - IDLE: on wrap_evt -> SETTLE, load settle counter with SETTLE-1.
  - SETTLE: decrement; at 0 -> CAPTURE.
  - CAPTURE: register d_in_ch5/6/7 into cap regs -> UPDATE.
  - UPDATE: per channel, sum <= sum + cap - oldest; shift cap into window, dropping oldest; fill counter saturates at 2^AVG_LOG2 -> OUTPUT.
  - OUTPUT: f_ch = sum >> AVG_LOG2; update line_det; assert out_valid; set win_full if fill counter is saturated -> IDLE.
- Latency: if wrap_evt is high in cycle N, out_valid is high in cycle N+SETTLE+3, exactly one cycle.
- Sum width is 12+AVG_LOG2 bits, unsigned, and never overflows. Truncating shift, no rounding.
- Before the window is full, missing taps are 0, so f_ch is biased low. out_valid still pulses; consumers qualify with win_full.
- Hysteresis per channel, evaluated on the new f_ch value:
  - value >= TH_HI -> bit = 1
  - value < TH_LO -> bit = 0
  - otherwise the bit holds
  - Exactly TH_LO holds; exactly TH_HI sets.
- wrap_evt while FSM != IDLE: the event is dropped and err_overrun is set (sticky until reset). A wrap_evt in the same cycle the FSM returns to IDLE is also dropped and flagged.
- Outputs hold their values between out_valid pulses.

Decomposition:
- Shared package adc_pkg holds:
  - constants ADC_W = 12, FRAME_CH7 = 2'd0, FRAME_CH5 = 2'd1, FRAME_CH6 = 2'd2
  - FSM state enum {IDLE, SETTLE, CAPTURE, UPDATE, OUTPUT}
- Sub-module mavg_ch (one per channel, three instances):
  - contains the window shift register, the running sum and the hysteresis bit
  - inputs: clk_50, rst_n, upd, out_en, sample[11:0]
  - outputs: avg[11:0], det
- The top level owns the synchronizer, wrap detect, FSM, fill counter and err_overrun.

Test Plan:
- Reset/idle: hold rst_n = 0, then release; data_frame static at 0 -> all outputs 0, no out_valid for 1000 cycles.
- Latency/fill: cycle data_frame 0->1->2->0 (320 cycles each), ch5 = 12'd2000 -> out_valid exactly SETTLE+3 cycles after wrap_evt.
  - f_ch5 = 500, 1000, 1500, 2000 on scans 1-4.
  - win_full rises with the 4th out_valid.
  - line_det[0] sets on scan 4 (2000 >= 1600), not scan 3 (1500).
- Hysteresis: steady ch6 window at 1600 -> det = 1. Step input to 1400 -> det stays 1 while avg passes 1550/1500/1450/1400. Step to 1399 window -> det = 0.
- Full scale: all channels 12'hFFF for 4 scans -> f_ch* = 4095, no overflow, line_det = 3'b111.
- Ignored transitions: data_frame 0->2->0 -> one wrap_evt. 1->0 and 0->1->0 -> no out_valid.
- Overrun and reset mid-op:
  - Force a second 2->0 wrap within SETTLE cycles -> single out_valid, err_overrun = 1, stays set.
  - Assert rst_n low during UPDATE -> no out_valid, all outputs 0.
